ahb_cmd_master: RTL and testbench

- AHB-Lite single-beat master with a command FIFO front-end. It sits directly upstream of the AHB slave on the point-to-point bus.
- A local client pushes read/write commands. The block queues them and issues them as pipelined NONSEQ transfers, overlapping one transfer's address phase with the previous transfer's data phase.
- It returns one response per command, in order. This replaces hand-driven bus tasks in benches and in the SoC.

---
 rtl/ahb_cmd_master.sv | 153 +++++++++++++++
 tb/tb_ahb_cmd_master.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_cmd_master.sv
// AHB-Lite single-beat master fed by a command FIFO. Commands are issued as
// pipelined NONSEQ transfers and each one returns a single in-order response.
module ahb_cmd_master #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    output logic              busy,
    output logic [ADDR_W-1:0] HADDR,
    output logic              HWRITE,
    output logic [1:0]        HTRANS,
    output logic [2:0]        HSIZE,
    output logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY,
    input  logic              HRESP
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] CNT_FULL = DEPTH[PTR_W:0];
    localparam logic [1:0] TRANS_IDLE = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    // Byte-lane bits never reach the bus; only the word address is queued.
    logic              w_unused_addr_lsb;
    assign w_unused_addr_lsb = ^cmd_addr[1:0];

    logic              r_fifo_write [DEPTH];
    logic [ADDR_W-3:0] r_fifo_addr  [DEPTH];
    logic [DATA_W-1:0] r_fifo_wdata [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [PTR_W:0]    r_count;
    logic [PTR_W:0]    w_count_d;

    logic              w_full;
    logic              w_push;
    logic              w_pop;

    logic              r_ap_valid;
    logic              r_ap_write;
    logic [ADDR_W-3:0] r_ap_addr;
    logic [DATA_W-1:0] r_ap_wdata;
    logic              r_dp_valid;
    logic              r_dp_write;
    logic [DATA_W-1:0] r_dp_wdata;

    logic              r_rsp_valid;
    logic              r_rsp_write;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_error;

    assign w_full = (r_count == CNT_FULL);
    assign w_push = cmd_valid && !w_full;
    // The FIFO head only advances into the address phase on a ready edge.
    assign w_pop  = HREADY && (r_count != '0);

    always_comb begin
        w_count_d = r_count;
        if (w_push && !w_pop) begin
            w_count_d = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_d = r_count - 1'b1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (w_push) begin
            r_fifo_write[r_wptr] <= cmd_write;
            r_fifo_addr[r_wptr]  <= cmd_addr[ADDR_W-1:2];
            r_fifo_wdata[r_wptr] <= cmd_wdata;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= w_count_d;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_ap_valid <= 1'b0;
            r_ap_write <= 1'b0;
            r_ap_addr  <= '0;
            r_ap_wdata <= '0;
            r_dp_valid <= 1'b0;
            r_dp_write <= 1'b0;
            r_dp_wdata <= '0;
        end else if (HREADY) begin
            r_dp_valid <= r_ap_valid;
            r_dp_write <= r_ap_write;
            r_dp_wdata <= r_ap_wdata;
            r_ap_valid <= w_pop;
            if (w_pop) begin
                r_ap_write <= r_fifo_write[r_rptr];
                r_ap_addr  <= r_fifo_addr[r_rptr];
                r_ap_wdata <= r_fifo_wdata[r_rptr];
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b0;
        end else begin
            r_rsp_valid <= HREADY && r_dp_valid;
            if (HREADY && r_dp_valid) begin
                r_rsp_write <= r_dp_write;
                r_rsp_rdata <= r_dp_write ? '0 : HRDATA;
                r_rsp_error <= HRESP;
            end
        end
    end

    assign cmd_ready = !w_full;
    assign busy      = (r_count != '0) || r_ap_valid || r_dp_valid;

    assign rsp_valid = r_rsp_valid;
    assign rsp_write = r_rsp_write;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_error = r_rsp_error;

    assign HADDR  = {r_ap_addr, 2'b00};
    assign HWRITE = r_ap_write;
    assign HTRANS = r_ap_valid ? TRANS_NONSEQ : TRANS_IDLE;
    assign HSIZE  = 3'b010;
    assign HWDATA = (r_dp_valid && r_dp_write) ? r_dp_wdata : '0;

endmodule

// File: tb/tb_ahb_cmd_master.sv
// Bench for ahb_cmd_master: memory slave with an error address, a reference
// memory/response queue model, directed timing checks and a random phase.
module tb_ahb_cmd_master;
    localparam int DEPTH = 4;
    localparam logic [31:0] ERR_ADDR = 32'hFFDF_FDFC;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        busy;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    int n_vec = 0;
    int n_err = 0;

    ahb_cmd_master #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error), .busy(busy),
        .HADDR(HADDR), .HWRITE(HWRITE), .HTRANS(HTRANS), .HSIZE(HSIZE),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory slave: captures the address phase, stores write data when the
    // data phase completes, never stores to the error address.
    logic        s_dp_valid;
    logic        s_dp_write;
    logic [31:0] s_dp_addr;
    logic [31:0] mem [logic [31:0]];

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            s_dp_valid <= 1'b0;
            s_dp_write <= 1'b0;
            s_dp_addr  <= '0;
            HRDATA     <= '0;
            HRESP      <= 1'b0;
        end else if (HREADY) begin
            if (s_dp_valid && s_dp_write && s_dp_addr != ERR_ADDR) mem[s_dp_addr] = HWDATA;
            s_dp_valid <= (HTRANS == 2'b10);
            s_dp_write <= HWRITE;
            s_dp_addr  <= HADDR;
            HRESP      <= (HTRANS == 2'b10) && (HADDR == ERR_ADDR);
            if (HTRANS == 2'b10 && !HWRITE && mem.exists(HADDR)) HRDATA <= mem[HADDR];
            else HRDATA <= '0;
        end
    end

    // Reference model: commands complete in order against a flat word memory.
    typedef struct {
        logic        w;
        logic [31:0] rd;
        logic        err;
    } rsp_t;
    rsp_t        exp_q[$];
    logic [31:0] ref_mem [logic [31:0]];

    function automatic void model_push(input logic w, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] wa;
        rsp_t        r;
        wa    = {a[31:2], 2'b00};
        r.w   = w;
        r.err = (wa == ERR_ADDR);
        r.rd  = '0;
        if (w) begin
            if (!r.err) ref_mem[wa] = d;
        end else if (ref_mem.exists(wa)) begin
            r.rd = ref_mem[wa];
        end
        exp_q.push_back(r);
    endfunction

    logic        hr_at_edge;
    logic        prev_ok = 1'b0;
    logic [31:0] p_haddr;
    logic [31:0] p_hwdata;
    logic [1:0]  p_htrans;
    logic        p_hwrite;

    always @(posedge HCLK) hr_at_edge = HREADY;

    always @(negedge HCLK) begin
        if (!HRESETn) begin
            prev_ok = 1'b0;
        end else begin
            check("hsize", HSIZE, 3'b010);
            check("htrans_legal", (HTRANS == 2'b00 || HTRANS == 2'b10), 1);
            check("haddr_align", HADDR[1:0], 0);
            if (rsp_valid) begin
                check("rsp_expected", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    rsp_t e;
                    e = exp_q.pop_front();
                    check("rsp_write", rsp_write, e.w);
                    check("rsp_rdata", rsp_rdata, e.rd);
                    check("rsp_error", rsp_error, e.err);
                end
            end
            if (prev_ok && hr_at_edge === 1'b0) begin
                check("stall_haddr", HADDR, p_haddr);
                check("stall_htrans", HTRANS, p_htrans);
                check("stall_hwrite", HWRITE, p_hwrite);
                check("stall_hwdata", HWDATA, p_hwdata);
                check("stall_no_rsp", rsp_valid, 0);
            end
            p_haddr  = HADDR;
            p_htrans = HTRANS;
            p_hwrite = HWRITE;
            p_hwdata = HWDATA;
            prev_ok  = 1'b1;
        end
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
    endtask

    task automatic drain();
        HREADY    = 1'b1;
        cmd_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge HCLK);
            #1;
            if (exp_q.size() == 0 && !busy) break;
        end
        check("drain_pending", exp_q.size(), 0);
        check("drain_busy", busy, 0);
        tick();
    endtask

    task automatic single(input logic w, input logic [31:0] a, input logic [31:0] d);
        drive(w, a, d);
        check("single_ready", cmd_ready, 1);
        model_push(w, a, d);
        tick();
        cmd_valid = 1'b0;
        check("single_e0_idle", HTRANS, 2'b00);
        check("single_e0_busy", busy, 1);
        tick();
        check("single_e1_nonseq", HTRANS, 2'b10);
        check("single_e1_haddr", HADDR, {a[31:2], 2'b00});
        check("single_e1_hwrite", HWRITE, w);
        tick();
        check("single_e2_idle", HTRANS, 2'b00);
        check("single_e2_hwdata", HWDATA, w ? d : 32'h0);
        check("single_e2_norsp", rsp_valid, 0);
        tick();
        check("single_e3_rsp", rsp_valid, 1);
        tick();
        check("single_e4_norsp", rsp_valid, 0);
        check("single_e4_idle", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] t_addr [6];
        logic [31:0] t_data [6];
        logic        t_wr   [6];
        logic [31:0] r_addrs [6];
        int          accepted;

        t_addr = '{32'h1000_0000, 32'h1000_0004, 32'h1000_0008,
                   32'h1000_0000, 32'h1000_0004, 32'h1000_0008};
        t_data = '{32'hAAAA_BBBB, 32'hCCCC_DDDD, 32'hEEEE_FFFF, 0, 0, 0};
        t_wr   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        r_addrs = '{32'h1000_0000, 32'h1000_0005, 32'h3000_0000,
                    ERR_ADDR, 32'h1000_000B, 32'h2000_0004};

        HRESETn   = 1'b0;
        HREADY    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        tick();
        tick();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_htrans", HTRANS, 0);
        check("rst_haddr", HADDR, 0);
        check("rst_hwrite", HWRITE, 0);
        check("rst_hwdata", HWDATA, 0);
        check("rst_rsp", {rsp_valid, rsp_write, rsp_error}, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_busy", busy, 0);
        HRESETn = 1'b1;
        tick();

        // Single write then readback with exact latency.
        single(1'b1, 32'h1000_0000, 32'hAAAA_BBBB);
        single(1'b0, 32'h1000_0000, 32'h0);

        // Six back-to-back commands: NONSEQ every cycle, HWDATA one cycle behind.
        for (int i = 0; i <= 6; i++) begin
            if (i < 6) begin
                drive(t_wr[i], t_addr[i], t_data[i]);
                check("b2b_ready", cmd_ready, 1);
                model_push(t_wr[i], t_addr[i], t_data[i]);
            end else begin
                cmd_valid = 1'b0;
            end
            tick();
            if (i >= 1) begin
                check("b2b_nonseq", HTRANS, 2'b10);
                check("b2b_haddr", HADDR, t_addr[i-1]);
            end
            if (i >= 2) check("b2b_hwdata", HWDATA, t_wr[i-2] ? t_data[i-2] : 32'h0);
        end
        tick();
        check("b2b_end_idle", HTRANS, 2'b00);
        check("b2b_end_hwdata", HWDATA, 32'h0);
        drain();

        // Fill: three ready edges then a stalled slave; DEPTH+2 pushes fit.
        accepted = 0;
        for (int k = 0; k < 10; k++) begin
            HREADY = (k < 3);
            drive(1'b1, 32'h2000_0000 + 32'(accepted * 4), 32'h5A00_0000 + 32'(accepted));
            if (k >= 6) check("fill_not_ready", cmd_ready, 0);
            if (cmd_ready) begin
                model_push(1'b1, cmd_addr, cmd_wdata);
                accepted++;
            end
            tick();
        end
        check("fill_accepted", accepted, DEPTH + 2);
        check("fill_full", cmd_ready, 0);
        drain();

        // Data-phase wait states on a write.
        drive(1'b1, 32'h3000_0000, 32'hABCD_EF01);
        model_push(1'b1, 32'h3000_0000, 32'hABCD_EF01);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        HREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wait_haddr", HADDR, 32'h3000_0000);
            check("wait_htrans", HTRANS, 2'b00);
            check("wait_hwdata", HWDATA, 32'hABCD_EF01);
            check("wait_norsp", rsp_valid, 0);
        end
        HREADY = 1'b1;
        tick();
        check("wait_rsp", rsp_valid, 1);
        tick();
        check("wait_rsp_once", rsp_valid, 0);
        single(1'b0, 32'h3000_0000, 32'h0);

        // Error responses do not disturb the following transfer.
        drive(1'b1, ERR_ADDR, 32'h1234_5678);
        model_push(1'b1, ERR_ADDR, 32'h1234_5678);
        tick();
        drive(1'b0, ERR_ADDR, 32'h0);
        model_push(1'b0, ERR_ADDR, 32'h0);
        tick();
        drive(1'b0, 32'h1000_0000, 32'h0);
        model_push(1'b0, 32'h1000_0000, 32'h0);
        tick();
        drain();

        // Reset with two queued, one in address phase and one in data phase.
        for (int k = 0; k < 4; k++) begin
            HREADY = (k < 3);
            drive(1'b0, 32'h1000_0000 + 32'(k * 4), 32'h0);
            model_push(1'b0, cmd_addr, 32'h0);
            tick();
        end
        cmd_valid = 1'b0;
        check("pre_rst_busy", busy, 1);
        check("pre_rst_nonseq", HTRANS, 2'b10);
        #1;
        HRESETn = 1'b0;
        #1;
        check("mid_rst_htrans", HTRANS, 2'b00);
        check("mid_rst_rsp", rsp_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", cmd_ready, 1);
        check("mid_rst_haddr", HADDR, 0);
        exp_q.delete();
        HREADY = 1'b1;
        @(negedge HCLK);
        #1;
        HRESETn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("post_rst_idle", HTRANS, 2'b00);
            check("post_rst_norsp", rsp_valid, 0);
        end
        check("post_rst_busy", busy, 0);

        // Random commands with random wait states against the model.
        for (int i = 0; i < 120; i++) begin
            logic [31:0] a;
            a = r_addrs[$urandom_range(0, 5)];
            HREADY = ($urandom_range(0, 3) != 0);
            drive(1'($urandom_range(0, 1)), a, $urandom);
            cmd_valid = 1'($urandom_range(0, 1));
            if (cmd_valid && cmd_ready) model_push(cmd_write, cmd_addr, cmd_wdata);
            tick();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
